// File: rtl/tile_seq_ctrl_if.sv
// Command, buffer and array handshake bundle for tile_seq_ctrl.
// master = the sequencer, slave = command source, buffers and array.
interface tile_seq_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_act_addr;
    logic [ADDR_W-1:0] cmd_wei_addr;
    logic [ADDR_W-1:0] cmd_out_addr;
    logic [DIM_W-1:0]  cmd_m;
    logic [DIM_W-1:0]  cmd_k;
    logic [DIM_W-1:0]  cmd_n;

    logic              uni_ready;
    logic              uni_busy;
    logic              uni_load;
    logic              uni_type;
    logic [ADDR_W-1:0] uni_init_addr;
    logic [DIM_W-1:0]  uni_row;
    logic [DIM_W-1:0]  uni_col;
    logic [DIM_W-1:0]  uni_stride;

    logic              wei_ready;
    logic              wei_busy;
    logic              wei_load;
    logic [ADDR_W-1:0] wei_init_addr;
    logic [DIM_W-1:0]  wei_row;
    logic [DIM_W-1:0]  wei_col;
    logic [DIM_W-1:0]  wei_stride;
    logic              wei_bank;

    logic              arr_start;
    logic              arr_acc;
    logic              arr_done;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_act_addr, cmd_wei_addr, cmd_out_addr, cmd_m, cmd_k, cmd_n,
        input  uni_ready, uni_busy, wei_ready, wei_busy, arr_done,
        output cmd_ready, uni_load, uni_type, uni_init_addr, uni_row, uni_col, uni_stride,
        output wei_load, wei_init_addr, wei_row, wei_col, wei_stride, wei_bank,
        output arr_start, arr_acc, done, err
    );

    modport slave (
        output cmd_valid, cmd_act_addr, cmd_wei_addr, cmd_out_addr, cmd_m, cmd_k, cmd_n,
        output uni_ready, uni_busy, wei_ready, wei_busy, arr_done,
        input  cmd_ready, uni_load, uni_type, uni_init_addr, uni_row, uni_col, uni_stride,
        input  wei_load, wei_init_addr, wei_row, wei_col, wei_stride, wei_bank,
        input  arr_start, arr_acc, done, err
    );
endinterface

// File: rtl/tile_seq_ctrl.sv
// Tiles one matmul command C[MxN] = A[MxK] * W[KxN] onto an ARRAY_DIM x ARRAY_DIM array.
// Define TILE_SEQ_DOUBLE_BUF_EN to prefetch the next weight tile into the other bank.
module tile_seq_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 10,
    parameter int ARRAY_DIM = 8
) (
    input logic             clk,
    input logic             reset,
    tile_seq_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_W_ISSUE, ST_W_WAIT, ST_A_ISSUE, ST_A_WAIT,
        ST_COMP, ST_C_WAIT, ST_S_ISSUE, ST_S_WAIT, ST_DONE
    } state_t;

    localparam logic [DIM_W-1:0] AD = DIM_W'(ARRAY_DIM);

    state_t            state_q;
    logic [ADDR_W-1:0] act_base_q, wei_base_q, out_base_q;
    logic [DIM_W-1:0]  m_q, k_q, n_q;
    logic [DIM_W-1:0]  k_off_q, n_off_q;
    logic [1:0]        wait_cnt_q;

    logic              cmd_ready_q, done_q, err_q;
    logic              uni_load_q, uni_type_q;
    logic [ADDR_W-1:0] uni_init_addr_q;
    logic [DIM_W-1:0]  uni_row_q, uni_col_q, uni_stride_q;
    logic              wei_load_q, wei_bank_q;
    logic [ADDR_W-1:0] wei_init_addr_q;
    logic [DIM_W-1:0]  wei_row_q, wei_col_q, wei_stride_q;
    logic              arr_start_q, arr_acc_q;

    logic [DIM_W-1:0]  k_rem_s, n_rem_s;
    logic              k_last_s, n_last_s, wait_ok_w_s, wait_ok_u_s, w_go_s;

    function automatic logic [DIM_W-1:0] tile_len(input logic [DIM_W-1:0] total,
                                                   input logic [DIM_W-1:0] off);
        logic [DIM_W-1:0] rem;
        rem = total - off;
        return (rem > AD) ? AD : rem;
    endfunction

    function automatic logic [ADDR_W-1:0] wei_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [DIM_W-1:0]  k_off,
                                                   input logic [DIM_W-1:0]  n_dim,
                                                   input logic [DIM_W-1:0]  n_off);
        return base + ADDR_W'(k_off) * ADDR_W'(n_dim) + ADDR_W'(n_off);
    endfunction

    // Offsets track kt*AD / nt*AD directly, so the last tile is where the remainder fits.
    assign k_rem_s     = k_q - k_off_q;
    assign n_rem_s     = n_q - n_off_q;
    assign k_last_s    = (k_rem_s <= AD);
    assign n_last_s    = (n_rem_s <= AD);
    assign wait_ok_w_s = (wait_cnt_q == 2'd2) && bus.wei_ready && !bus.wei_busy;
    assign wait_ok_u_s = (wait_cnt_q == 2'd2) && bus.uni_ready && !bus.uni_busy;

`ifdef TILE_SEQ_DOUBLE_BUF_EN
    typedef enum logic [1:0] {PF_IDLE, PF_WAIT, PF_DONE} pf_t;
    pf_t              pf_q;
    logic [1:0]       pf_cnt_q;
    logic             first_q;
    logic [DIM_W-1:0] nk_off_s, nn_off_s;

    assign nk_off_s = k_last_s ? {DIM_W{1'b0}} : (k_off_q + AD);
    assign nn_off_s = k_last_s ? (n_off_q + AD) : n_off_q;
    assign w_go_s   = (pf_q == PF_IDLE) && bus.wei_ready && !bus.wei_busy;
`else
    assign w_go_s   = bus.wei_ready && !bus.wei_busy;
`endif

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.uni_load      = uni_load_q;
    assign bus.uni_type      = uni_type_q;
    assign bus.uni_init_addr = uni_init_addr_q;
    assign bus.uni_row       = uni_row_q;
    assign bus.uni_col       = uni_col_q;
    assign bus.uni_stride    = uni_stride_q;
    assign bus.wei_load      = wei_load_q;
    assign bus.wei_init_addr = wei_init_addr_q;
    assign bus.wei_row       = wei_row_q;
    assign bus.wei_col       = wei_col_q;
    assign bus.wei_stride    = wei_stride_q;
    assign bus.wei_bank      = wei_bank_q;
    assign bus.arr_start     = arr_start_q;
    assign bus.arr_acc       = arr_acc_q;

    // Tile sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            act_base_q      <= {ADDR_W{1'b0}};
            wei_base_q      <= {ADDR_W{1'b0}};
            out_base_q      <= {ADDR_W{1'b0}};
            m_q             <= {DIM_W{1'b0}};
            k_q             <= {DIM_W{1'b0}};
            n_q             <= {DIM_W{1'b0}};
            k_off_q         <= {DIM_W{1'b0}};
            n_off_q         <= {DIM_W{1'b0}};
            wait_cnt_q      <= 2'd0;
            cmd_ready_q     <= 1'b1;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            uni_load_q      <= 1'b0;
            uni_type_q      <= 1'b0;
            uni_init_addr_q <= {ADDR_W{1'b0}};
            uni_row_q       <= {DIM_W{1'b0}};
            uni_col_q       <= {DIM_W{1'b0}};
            uni_stride_q    <= {DIM_W{1'b0}};
            wei_load_q      <= 1'b0;
            wei_bank_q      <= 1'b0;
            wei_init_addr_q <= {ADDR_W{1'b0}};
            wei_row_q       <= {DIM_W{1'b0}};
            wei_col_q       <= {DIM_W{1'b0}};
            wei_stride_q    <= {DIM_W{1'b0}};
            arr_start_q     <= 1'b0;
            arr_acc_q       <= 1'b0;
`ifdef TILE_SEQ_DOUBLE_BUF_EN
            pf_q            <= PF_IDLE;
            pf_cnt_q        <= 2'd0;
            first_q         <= 1'b1;
`endif
        end else begin
            wei_load_q  <= 1'b0;
            uni_load_q  <= 1'b0;
            arr_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            // Saturating count of cycles since the last load pulse.
            if (wait_cnt_q != 2'd2) begin
                wait_cnt_q <= wait_cnt_q + 2'd1;
            end
`ifdef TILE_SEQ_DOUBLE_BUF_EN
            if (pf_cnt_q != 2'd2) begin
                pf_cnt_q <= pf_cnt_q + 2'd1;
            end
            if ((pf_q == PF_WAIT) && (pf_cnt_q == 2'd2) && bus.wei_ready && !bus.wei_busy) begin
                pf_q <= PF_DONE;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        act_base_q <= bus.cmd_act_addr;
                        wei_base_q <= bus.cmd_wei_addr;
                        out_base_q <= bus.cmd_out_addr;
                        m_q        <= bus.cmd_m;
                        k_q        <= bus.cmd_k;
                        n_q        <= bus.cmd_n;
                        k_off_q    <= {DIM_W{1'b0}};
                        n_off_q    <= {DIM_W{1'b0}};
`ifdef TILE_SEQ_DOUBLE_BUF_EN
                        first_q    <= 1'b1;
`endif
                        if ((bus.cmd_m == {DIM_W{1'b0}}) || (bus.cmd_k == {DIM_W{1'b0}}) ||
                            (bus.cmd_n == {DIM_W{1'b0}})) begin
                            err_q <= 1'b1;
                        end else begin
                            cmd_ready_q <= 1'b0;
                            state_q     <= ST_W_ISSUE;
                        end
                    end
                end
                ST_W_ISSUE: begin
`ifdef TILE_SEQ_DOUBLE_BUF_EN
                    if (pf_q == PF_DONE) begin
                        pf_q    <= PF_IDLE;
                        state_q <= ST_A_ISSUE;
                    end else
`endif
                    if (w_go_s) begin
                        wei_load_q      <= 1'b1;
                        wei_init_addr_q <= wei_addr(wei_base_q, k_off_q, n_q, n_off_q);
                        wei_row_q       <= tile_len(k_q, k_off_q);
                        wei_col_q       <= tile_len(n_q, n_off_q);
                        wei_stride_q    <= n_q;
                        wait_cnt_q      <= 2'd0;
                        state_q         <= ST_W_WAIT;
                    end
                end
                ST_W_WAIT: begin
                    if (wait_ok_w_s) begin
                        state_q <= ST_A_ISSUE;
                    end
                end
                ST_A_ISSUE: begin
                    if (bus.uni_ready && !bus.uni_busy) begin
                        uni_load_q      <= 1'b1;
                        uni_type_q      <= 1'b0;
                        uni_init_addr_q <= act_base_q + ADDR_W'(k_off_q);
                        uni_row_q       <= m_q;
                        uni_col_q       <= tile_len(k_q, k_off_q);
                        uni_stride_q    <= k_q;
                        wait_cnt_q      <= 2'd0;
                        state_q         <= ST_A_WAIT;
                    end
                end
                ST_A_WAIT: begin
                    if (wait_ok_u_s) begin
                        state_q <= ST_COMP;
                    end
                end
                ST_COMP: begin
                    arr_start_q <= 1'b1;
                    arr_acc_q   <= (k_off_q != {DIM_W{1'b0}});
`ifdef TILE_SEQ_DOUBLE_BUF_EN
                    if (!first_q) begin
                        wei_bank_q <= ~wei_bank_q;
                    end
                    first_q <= 1'b0;
`endif
                    state_q <= ST_C_WAIT;
                end
                ST_C_WAIT: begin
`ifdef TILE_SEQ_DOUBLE_BUF_EN
                    // Next tile's weights go into the idle bank while the array computes.
                    if ((pf_q == PF_IDLE) && !(k_last_s && n_last_s) &&
                        bus.wei_ready && !bus.wei_busy) begin
                        wei_load_q      <= 1'b1;
                        wei_init_addr_q <= wei_addr(wei_base_q, nk_off_s, n_q, nn_off_s);
                        wei_row_q       <= tile_len(k_q, nk_off_s);
                        wei_col_q       <= tile_len(n_q, nn_off_s);
                        wei_stride_q    <= n_q;
                        pf_q            <= PF_WAIT;
                        pf_cnt_q        <= 2'd0;
                    end
`endif
                    if (bus.arr_done) begin
                        if (k_last_s) begin
                            state_q <= ST_S_ISSUE;
                        end else begin
                            k_off_q <= k_off_q + AD;
                            state_q <= ST_W_ISSUE;
                        end
                    end
                end
                ST_S_ISSUE: begin
                    if (bus.uni_ready && !bus.uni_busy) begin
                        uni_load_q      <= 1'b1;
                        uni_type_q      <= 1'b1;
                        uni_init_addr_q <= out_base_q + ADDR_W'(n_off_q);
                        uni_row_q       <= m_q;
                        uni_col_q       <= tile_len(n_q, n_off_q);
                        uni_stride_q    <= n_q;
                        wait_cnt_q      <= 2'd0;
                        state_q         <= ST_S_WAIT;
                    end
                end
                ST_S_WAIT: begin
                    if (wait_ok_u_s) begin
                        if (n_last_s) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            n_off_q <= n_off_q + AD;
                            k_off_q <= {DIM_W{1'b0}};
                            state_q <= ST_W_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Scoreboard bench for tile_seq_ctrl: directed commands with hand-computed tile sequences.
module tb_tile_seq_ctrl;
    localparam int ADDR_W = 32;
    localparam int DIM_W  = 10;

    typedef enum logic [2:0] {EV_NONE, EV_W, EV_U, EV_A, EV_D, EV_E} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [9:0]  stride;
        logic        flag;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic uni_hold;
    ev_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;

    tile_seq_ctrl_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    tile_seq_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .ARRAY_DIM(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(input ev_kind_t k, input logic [31:0] a, input logic [9:0] r,
                               input logic [9:0] c, input logic [9:0] s, input logic f);
        ev_t e;
        e.kind = k; e.addr = a; e.row = r; e.col = c; e.stride = s; e.flag = f;
        return e;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [9:0] r,
                        input logic [9:0] c, input logic [9:0] s, input logic f);
        sb_q.push_back(mk(k, a, r, c, s, f));
    endtask

    task automatic mon_ev(input ev_t act);
        ev_t exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%0h expected=none", act);
        end else begin
            exp = sb_q.pop_front();
            check("sb_event", 160'(act), 160'(exp));
        end
    endtask

    function automatic logic [159:0] outs_vec();
        return 160'({bus.cmd_ready, bus.uni_load, bus.uni_type, bus.uni_init_addr, bus.uni_row,
                     bus.uni_col, bus.uni_stride, bus.wei_load, bus.wei_init_addr, bus.wei_row,
                     bus.wei_col, bus.wei_stride, bus.wei_bank, bus.arr_start, bus.arr_acc,
                     bus.done, bus.err});
    endfunction

    // Monitor: every output pulse is compared with the next expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (bus.wei_load === 1'b1)
                    mon_ev(mk(EV_W, bus.wei_init_addr, bus.wei_row, bus.wei_col, bus.wei_stride, bus.wei_bank));
                if (bus.uni_load === 1'b1)
                    mon_ev(mk(EV_U, bus.uni_init_addr, bus.uni_row, bus.uni_col, bus.uni_stride, bus.uni_type));
                if (bus.arr_start === 1'b1)
                    mon_ev(mk(EV_A, 32'd0, 10'd0, 10'd0, 10'd0, bus.arr_acc));
                if (bus.done === 1'b1)
                    mon_ev(mk(EV_D, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0));
                if (bus.err === 1'b1)
                    mon_ev(mk(EV_E, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0));
            end
        end
    end

    // Weight buffer model: busy from the cycle after the pulse for three cycles.
    initial begin
        int cnt;
        cnt = 0;
        bus.wei_busy  = 1'b0;
        bus.wei_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.wei_load === 1'b1)
                check("wei_pulse_handshake", 160'({bus.wei_ready, bus.wei_busy}), 160'(2'b10));
            bus.wei_busy = (cnt != 0);
            if (cnt != 0) cnt--;
            if (bus.wei_load === 1'b1) cnt = 3;
        end
    end

    // Unified buffer model; ready can be withheld by the stimulus.
    initial begin
        int cnt;
        cnt = 0;
        bus.uni_busy  = 1'b0;
        bus.uni_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.uni_load === 1'b1)
                check("uni_pulse_handshake", 160'({bus.uni_ready, bus.uni_busy}), 160'(2'b10));
            bus.uni_busy  = (cnt != 0);
            bus.uni_ready = ~uni_hold;
            if (cnt != 0) cnt--;
            if (bus.uni_load === 1'b1) cnt = 2;
        end
    end

    // Array model: arr_done four cycles after arr_start.
    initial begin
        int acnt;
        acnt = 0;
        bus.arr_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.arr_done = 1'b0;
            if (acnt != 0) begin
                acnt--;
                if (acnt == 0) bus.arr_done = 1'b1;
            end
            if (bus.arr_start === 1'b1) acnt = 4;
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] w, input logic [31:0] o,
                            input logic [9:0] m, input logic [9:0] k, input logic [9:0] n);
        @(negedge clk);
        check("cmd_ready_idle", 160'(bus.cmd_ready), 160'(1'b1));
        bus.cmd_valid    = 1'b1;
        bus.cmd_act_addr = a;
        bus.cmd_wei_addr = w;
        bus.cmd_out_addr = o;
        bus.cmd_m        = m;
        bus.cmd_k        = k;
        bus.cmd_n        = n;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.done === 1'b1 || bus.err === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_wei_pulse(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.wei_load === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_wei_load expected=wei_load", name);
        end
    endtask

    task automatic push_t1();
        push(EV_W, 32'h200, 10'd8, 10'd8, 10'd8, 1'b0);
        push(EV_U, 32'h100, 10'd4, 10'd8, 10'd8, 1'b0);
        push(EV_A, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        push(EV_U, 32'h300, 10'd4, 10'd8, 10'd8, 1'b1);
        push(EV_D, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
    endtask

    initial begin
        logic [159:0] rst_exp;
        rst_exp       = 160'd0;
        rst_exp[132]  = 1'b1;
        reset         = 1'b1;
        uni_hold      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_act_addr = 32'd0;
        bus.cmd_wei_addr = 32'd0;
        bus.cmd_out_addr = 32'd0;
        bus.cmd_m = 10'd0;
        bus.cmd_k = 10'd0;
        bus.cmd_n = 10'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_vec(), rst_exp);
        reset = 1'b0;

        // Single tile.
        push_t1();
        send_cmd(32'h100, 32'h200, 32'h300, 10'd4, 10'd8, 10'd8);
        wait_end("t1");

        // K accumulation across three k tiles, last one partial.
        push(EV_W, 32'd0,    10'd8, 10'd8, 10'd8,  1'b0);
        push(EV_U, 32'h1000, 10'd2, 10'd8, 10'd20, 1'b0);
        push(EV_A, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        push(EV_W, 32'd64,   10'd8, 10'd8, 10'd8,  1'b0);
        push(EV_U, 32'h1008, 10'd2, 10'd8, 10'd20, 1'b0);
        push(EV_A, 32'd0, 10'd0, 10'd0, 10'd0, 1'b1);
        push(EV_W, 32'd128,  10'd4, 10'd8, 10'd8,  1'b0);
        push(EV_U, 32'h1010, 10'd2, 10'd4, 10'd20, 1'b0);
        push(EV_A, 32'd0, 10'd0, 10'd0, 10'd0, 1'b1);
        push(EV_U, 32'h2000, 10'd2, 10'd8, 10'd8,  1'b1);
        push(EV_D, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        send_cmd(32'h1000, 32'd0, 32'h2000, 10'd2, 10'd20, 10'd8);
        wait_end("t2");

        // Two n tiles, second one partial.
        push(EV_W, 32'h500, 10'd8, 10'd8, 10'd12, 1'b0);
        push(EV_U, 32'h600, 10'd3, 10'd8, 10'd8,  1'b0);
        push(EV_A, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        push(EV_U, 32'h700, 10'd3, 10'd8, 10'd12, 1'b1);
        push(EV_W, 32'h508, 10'd8, 10'd4, 10'd12, 1'b0);
        push(EV_U, 32'h600, 10'd3, 10'd8, 10'd8,  1'b0);
        push(EV_A, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        push(EV_U, 32'h708, 10'd3, 10'd4, 10'd12, 1'b1);
        push(EV_D, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        send_cmd(32'h600, 32'h500, 32'h700, 10'd3, 10'd8, 10'd12);
        wait_end("t3");

        // Zero dimension: err only, cmd_ready stays high.
        push(EV_E, 32'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        send_cmd(32'h100, 32'h200, 32'h300, 10'd4, 10'd8, 10'd0);
        check("err_next_cycle", 160'(bus.err), 160'(1'b1));
        check("err_cmd_ready", 160'(bus.cmd_ready), 160'(1'b1));
        @(negedge clk);
        check("err_single_pulse", 160'(bus.err), 160'(1'b0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("err_cmd_ready_hold", 160'(bus.cmd_ready), 160'(1'b1));
        end

        // Unified buffer not ready: no pulse, outputs keep the previous store setup.
        uni_hold = 1'b1;
        push_t1();
        send_cmd(32'h100, 32'h200, 32'h300, 10'd4, 10'd8, 10'd8);
        wait_wei_pulse("t5");
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("stall_no_uni_load", 160'(bus.uni_load), 160'(1'b0));
            check("stall_uni_stable",
                  160'({bus.uni_type, bus.uni_init_addr, bus.uni_row, bus.uni_col, bus.uni_stride}),
                  160'({1'b1, 32'h708, 10'd3, 10'd4, 10'd12}));
        end
        uni_hold = 1'b0;
        wait_end("t5");

        // Reset during W_WAIT, then a fresh command from the first tile.
        push(EV_W, 32'h200, 10'd8, 10'd8, 10'd8, 1'b0);
        send_cmd(32'h100, 32'h200, 32'h300, 10'd4, 10'd8, 10'd8);
        wait_wei_pulse("t6");
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_outputs", outs_vec(), rst_exp);
        check("midrun_reset_sb_empty", 160'(sb_q.size()), 160'(0));
        @(negedge clk);
        reset = 1'b0;
        push_t1();
        send_cmd(32'h100, 32'h200, 32'h300, 10'd4, 10'd8, 10'd8);
        wait_end("t6");

        check("sb_drained", 160'(sb_q.size()), 160'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_seq_ctrl.md
Name: tile_seq_ctrl

Overview:
- Parametrised successor to the accelerator's single-shot buffer controller.
- Accepts one matmul command, C[M×N] = A[M×K] · W[K×N], and tiles it onto an ARRAY_DIM×ARRAY_DIM systolic array.
- Per tile, sequences weighting-buffer loads, unified-buffer activation loads, array compute and unified-buffer result stores.
- Handles partial edge tiles and K-accumulation, with per-buffer ready/busy handshakes.

Parameters:
ADDR_W, 32, buffer address width (word-addressed)
DIM_W, 10, width of M/K/N and row/col/stride fields
ARRAY_DIM, 8, systolic array edge (power of two, ≤ 2^DIM_W-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
cmd_act_addr / cmd_wei_addr / cmd_out_addr  in  ADDR_W  base addresses of A, W, C (row-major)
cmd_m / cmd_k / cmd_n  in  DIM_W  matrix dimensions
uni_ready  in  1  unified buffer can accept a request
uni_busy  in  1  unified buffer transfer in progress
uni_load  out  1  one-cycle request pulse
uni_type  out  1  0 = load activations to array, 1 = store array results
uni_init_addr  out  ADDR_W  tile start address
uni_row / uni_col / uni_stride  out  DIM_W  tile rows, cols, row stride
wei_ready / wei_busy  in  1  weighting buffer handshake
wei_load  out  1  one-cycle request pulse
wei_init_addr  out  ADDR_W  weight tile start address
wei_row / wei_col / wei_stride  out  DIM_W  weight tile shape and stride
wei_bank  out  1  array weight bank targeted
arr_start  out  1  one-cycle compute start
arr_acc  out  1  1 = accumulate onto existing partial sums
arr_done  in  1  one-cycle compute-complete pulse
done  out  1  one-cycle pulse, command finished
err  out  1  one-cycle pulse, command rejected

Behaviour:
- Reset: IDLE; every output 0 except cmd_ready=1; tile counters and latched command cleared.
- Acceptance: command fields are latched on the accept cycle.
  - If any dimension is 0: err pulses next cycle, the FSM stays in IDLE, no buffer traffic.
- Tile loop order: nt outer (0..ceil(N/AD)-1), kt inner (0..ceil(K/AD)-1), where AD = ARRAY_DIM.
  - k_len = min(AD, K-kt·AD); n_len = min(AD, N-nt·AD).
- Weight tile:
  - wei_init_addr = wei_base + kt·AD·N + nt·AD
  - wei_row = k_len, wei_col = n_len, wei_stride = N
- Activation tile:
  - uni_type = 0, uni_init_addr = act_base + kt·AD
  - uni_row = M, uni_col = k_len, uni_stride = K
- Store (after the last kt only):
  - uni_type = 1, uni_init_addr = out_base + nt·AD
  - uni_row = M, uni_col = n_len, uni_stride = N
- arr_acc = (kt != 0).
- Address arithmetic is done at ADDR_W, products zero-extended; overflow wraps modulo 2^ADDR_W.
- FSM: IDLE → W_ISSUE → W_WAIT → A_ISSUE → A_WAIT → COMP → C_WAIT → (next kt: W_ISSUE | last kt: S_ISSUE → S_WAIT → next nt: W_ISSUE | last: DONE) → IDLE.
- ISSUE states:
  - Pulse load for exactly one cycle, only in a cycle where ready=1 && busy=0; otherwise hold in ISSUE.
  - Address/shape outputs are valid in the pulse cycle and held stable through the matching WAIT state.
- WAIT states: leave when busy=0 && ready=1, sampled no earlier than 2 cycles after the pulse. Buffers must raise busy the cycle after the pulse.
- COMP: arr_start pulses one cycle, then C_WAIT holds until arr_done. An arr_done arriving in any other state is ignored.
- DONE: done pulses one cycle, then IDLE with cmd_ready=1 the following cycle.
- wei_bank stays 0 without the optional feature.
- Reset mid-operation (any state): synchronous return to reset values next edge; any in-flight buffer transfer is abandoned.

Optional Feature:
- Macro: TILE_SEQ_DOUBLE_BUF_EN.
- When defined:
  - The weight load for the next (kt,nt) tile is issued during C_WAIT of the current tile, into bank ~wei_bank.
  - wei_bank toggles at each arr_start after the first.
  - W_ISSUE/W_WAIT are skipped when the prefetch has already completed.
  - arr_start is still gated on both the weight and activation loads being complete.
- When undefined: strictly serial sequence, wei_bank tied to 0.

Test Plan:
- M=4,K=8,N=8, bases 0x100/0x200/0x300 → wei_load@0x200 (8×8, stride 8); uni_load type0@0x100 (4×8, stride 8); arr_start with acc=0; uni_load type1@0x300 (4×8); done; no err.
- K=20,N=8,M=2, wei_base 0 → three weight loads @0,64,128 with row 8,8,4; arr_acc 0,1,1; one store.
- N=12,K=8,M=3 → two n tiles: weight col 8,4; stores @out+0 and out+8 with col 8,4.
- cmd_n=0 → err pulse one cycle later; no load or arr_start pulses; cmd_ready=1 throughout.
- uni_ready held 0 for 10 cycles in A_ISSUE → uni_load stays 0 and outputs stay stable; single pulse once ready=1.
- reset asserted during W_WAIT → next cycle all outputs 0, cmd_ready=1; a new command then runs from kt=nt=0.
